// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity modes, data-width encoding
// and the receiver frame states.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b10,
    ODD  = 2'b11
  } parity_t;

  typedef enum logic [1:0] {
    DBITS_5 = 2'b00,
    DBITS_6 = 2'b01,
    DBITS_7 = 2'b10,
    DBITS_8 = 2'b11
  } data_bits_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2
  } rx_state_t;

  // Both 00 and 01 mean "no parity"; only the upper bit enables it.
  function automatic parity_t decode_parity(input logic [1:0] cfg);
    if (!cfg[1]) return NONE;
    return cfg[0] ? ODD : EVEN;
  endfunction

  function automatic logic [2:0] last_bit_index(input data_bits_t bits);
    return 3'd4 + {1'b0, bits};
  endfunction

endpackage

// File: rtl/fifo.sv
// First-word-fall-through FIFO; writes when full and reads when empty are ignored,
// and the head reads as zero while empty.
module fifo #(
  parameter int XLEN  = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [XLEN-1:0]          i_data,
  output logic [XLEN-1:0]          o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [AW:0]     r_wr;
  logic [AW:0]     r_rd;
  logic            w_wr_en;
  logic            w_rd_en;

  assign o_count = r_wr - r_rd;
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (o_count == FULL_COUNT);
  assign w_wr_en = i_push & ~o_full;
  assign w_rd_en = i_pop & ~o_empty;
  assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_rd_en) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, per-bit tick counter and 3-sample majority vote
// taken at ticks mid-1, mid and mid+1 of every bit period.
module uart_rx_sampler #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_rx,
  input  logic i_active,
  output logic o_start_edge,
  output logic o_bit_valid,
  output logic o_bit_value
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  logic [CW-1:0]          r_cnt;
  logic                   r_s0;
  logic                   r_s1;
  logic                   w_rx;

  assign w_rx = r_sync[SYNC_STAGES-1];

  // Counter is held at zero while idle so the start-edge tick is tick 0 of the start bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
      r_cnt     <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      if (i_tick) r_rx_prev <= w_rx;
      if (!i_active) r_cnt <= '0;
      else if (i_tick) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      if (i_tick && r_cnt == MID - 1'b1) r_s0 <= w_rx;
      if (i_tick && r_cnt == MID) r_s1 <= w_rx;
    end
  end

  assign o_start_edge = i_tick & r_rx_prev & ~w_rx;
  assign o_bit_valid  = i_active & i_tick & (r_cnt == MID + 1'b1);
  assign o_bit_value  = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: frame FSM over the majority-vote sampler, character queue
// and sticky parity/frame/overrun/break flags.
import uart_pkg::*;

module uart_rx_engine #(
  parameter int OVERSAMPLE  = 16,
  parameter int QUEUE_DEPTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_sample_tick,
  input  logic                           i_rx,
  input  logic [1:0]                     i_cfg_data_bits,
  input  logic [1:0]                     i_cfg_parity,
  input  logic                           i_cfg_two_stop,
  input  logic                           i_re,
  input  logic                           i_err_clr,
  output logic [7:0]                     o_dout,
  output logic                           o_empty,
  output logic                           o_full,
  output logic [$clog2(QUEUE_DEPTH):0]   o_count,
  output logic                           o_busy,
  output logic                           o_parity_err,
  output logic                           o_frame_err,
  output logic                           o_overrun,
  output logic                           o_break_det
);

  rx_state_t  r_state, w_next;
  data_bits_t r_bits;
  parity_t    r_parity;
  logic       r_two_stop;
  logic [7:0] r_data;
  logic [2:0] r_bit_idx;
  logic       r_all_zero;
  logic       r_done;
  logic       r_parity_err, r_frame_err, r_overrun, r_break;
  logic       w_start_edge, w_bit_valid, w_bit_value;
  logic       w_busy, w_last_stop, w_set_perr, w_set_ferr, w_push, w_full;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_sample_tick), .i_rx(i_rx),
    .i_active(w_busy), .o_start_edge(w_start_edge), .o_bit_valid(w_bit_valid),
    .o_bit_value(w_bit_value)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_start_edge) w_next = START;
      START:  if (w_bit_valid) w_next = w_bit_value ? IDLE : DATA;
      DATA:   if (w_bit_valid && r_bit_idx == last_bit_index(r_bits))
                w_next = (r_parity == NONE) ? STOP : PARITY;
      PARITY: if (w_bit_valid) w_next = STOP;
      STOP:   if (w_bit_valid) w_next = r_two_stop ? STOP2 : IDLE;
      STOP2:  if (w_bit_valid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != IDLE);
    w_last_stop = w_bit_valid && ((r_state == STOP && !r_two_stop) || r_state == STOP2);
    w_set_ferr  = w_bit_valid && (r_state == STOP || r_state == STOP2) && !w_bit_value;
    w_set_perr  = w_bit_valid && (r_state == PARITY) &&
                  ((^r_data) ^ w_bit_value ^ (r_parity == ODD));
  end

  // A frame that is zero from start through the last stop bit is a break, not a character.
  assign w_push = r_done & ~r_all_zero;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bits       <= DBITS_8;
      r_parity     <= NONE;
      r_two_stop   <= 1'b0;
      r_data       <= '0;
      r_bit_idx    <= '0;
      r_all_zero   <= 1'b0;
      r_done       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_break      <= 1'b0;
    end else begin
      r_done <= w_last_stop;
      if (r_state == START && w_bit_valid && !w_bit_value) begin
        r_bits     <= data_bits_t'(i_cfg_data_bits);
        r_parity   <= decode_parity(i_cfg_parity);
        r_two_stop <= i_cfg_two_stop;
        r_data     <= '0;
        r_bit_idx  <= '0;
        r_all_zero <= 1'b1;
      end else if (w_bit_valid && w_busy && r_state != START) begin
        r_all_zero <= r_all_zero & ~w_bit_value;
      end
      if (r_state == DATA && w_bit_valid) begin
        r_data[r_bit_idx] <= w_bit_value;
        r_bit_idx         <= r_bit_idx + 1'b1;
      end
      r_parity_err <= (r_parity_err & ~i_err_clr) | w_set_perr;
      r_frame_err  <= (r_frame_err & ~i_err_clr) | w_set_ferr;
      r_overrun    <= (r_overrun & ~i_err_clr) | (w_push & w_full);
      r_break      <= (r_break & ~i_err_clr) | (r_done & r_all_zero);
    end
  end

  fifo #(.XLEN(8), .DEPTH(QUEUE_DEPTH)) u_queue (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(w_push), .i_pop(i_re),
    .i_data(r_data), .o_data(o_dout), .o_empty(o_empty), .o_full(w_full),
    .o_count(o_count)
  );

  assign o_full       = w_full;
  assign o_busy       = w_busy;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
  assign o_break_det  = r_break;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: table of framed characters plus
// hand-written false-start, break, overrun and mid-frame-reset sequences.
module tb_uart_rx_engine;

  localparam int OS    = 16;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sampleTick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] cfgDataBits = 2'b11;
  logic [1:0] cfgParity = 2'b00;
  logic       cfgTwoStop = 1'b0;
  logic       re = 1'b0;
  logic       errClr = 1'b0;
  logic [7:0] dout;
  logic       empty, full, busy, parityErr, frameErr, overrun, breakDet;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad = 0;
  logic [7:0] expQ[$];
  logic [1:0] tickDiv = 2'd0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] bits;
    logic [1:0] par;
    logic       twoStop;
    logic       badPar;
    logic       stopVal;
    logic [7:0] expDout;
    logic       expPerr;
    logic       expFerr;
  } vec_t;

  vec_t vecs[7];

  uart_rx_engine #(.OVERSAMPLE(OS), .QUEUE_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_sample_tick(sampleTick), .i_rx(rx),
    .i_cfg_data_bits(cfgDataBits), .i_cfg_parity(cfgParity), .i_cfg_two_stop(cfgTwoStop),
    .i_re(re), .i_err_clr(errClr), .o_dout(dout), .o_empty(empty), .o_full(full),
    .o_count(count), .o_busy(busy), .o_parity_err(parityErr), .o_frame_err(frameErr),
    .o_overrun(overrun), .o_break_det(breakDet)
  );

  always #5 clk = ~clk;

  // One tick every four clocks, updated on the falling edge.
  always @(negedge clk) begin
    tickDiv = tickDiv + 2'd1;
    sampleTick = (tickDiv == 2'd0);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] flagVec();
    return {parityErr, frameErr, overrun, breakDet};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (sampleTick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic setRx(input logic v);
    @(negedge clk);
    rx = v;
  endtask

  task automatic sendBit(input logic v);
    setRx(v);
    waitTicks(OS);
  endtask

  task automatic clearErrors();
    @(negedge clk);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
  endtask

  // Configuration is scrambled after the start bit; the frame must keep the latched settings.
  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] bits, input logic [1:0] par,
                               input logic twoStop, input logic badPar, input logic stopVal);
    int n;
    logic [7:0] d;
    logic p;
    n = 5 + int'(bits);
    d = data;
    for (int i = 0; i < 8; i++) if (i >= n) d[i] = 1'b0;
    cfgDataBits = bits;
    cfgParity = par;
    cfgTwoStop = twoStop;
    sendBit(1'b0);
    cfgDataBits = 2'($urandom);
    cfgParity = 2'($urandom);
    cfgTwoStop = 1'($urandom);
    for (int i = 0; i < n; i++) sendBit(d[i]);
    if (par[1]) begin
      p = (^d) ^ par[0] ^ badPar;
      sendBit(p);
    end
    sendBit(stopVal);
    if (twoStop) sendBit(stopVal);
    setRx(1'b1);
    waitTicks(4);
  endtask

  task automatic popCheck(input string name);
    logic [7:0] exp;
    @(negedge clk);
    checkOutput({name, "_empty"}, 32'(empty), 32'd0);
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: scoreboard empty, dout=%0h", name, dout);
    end else begin
      exp = expQ.pop_front();
      checkOutput(name, 32'(dout), 32'(exp));
    end
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h1F, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h6B, 2'b10, 2'b11, 1'b0, 1'b0, 1'b1, 8'h6B, 1'b0, 1'b0};
    vecs[4] = '{8'hF3, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};

    repeat (5) @(negedge clk);
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    checkOutput("reset_flags", 32'(flagVec()), 32'd0);
    rst = 1'b0;
    waitTicks(4);

    foreach (vecs[k]) begin
      expQ.push_back(vecs[k].expDout);
      applyStimulus(vecs[k].data, vecs[k].bits, vecs[k].par, vecs[k].twoStop,
                    vecs[k].badPar, vecs[k].stopVal);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_count", k), 32'(count), 32'd1);
      checkOutput($sformatf("vec%0d_flags", k), 32'(flagVec()),
                  32'({vecs[k].expPerr, vecs[k].expFerr, 2'b00}));
      popCheck($sformatf("vec%0d_dout", k));
      clearErrors();
      @(negedge clk);
      checkOutput($sformatf("vec%0d_cleared", k), 32'({flagVec(), count}), 32'd0);
    end

    setRx(1'b0);
    waitTicks(3);
    @(negedge clk);
    checkOutput("false_start_busy_high", 32'(busy), 32'd1);
    waitTicks(3);
    setRx(1'b1);
    waitTicks(12);
    @(negedge clk);
    checkOutput("false_start_busy_low", 32'(busy), 32'd0);
    checkOutput("false_start_count", 32'(count), 32'd0);
    checkOutput("false_start_flags", 32'(flagVec()), 32'd0);

    applyStimulus(8'h00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("break_count", 32'(count), 32'd0);
    checkOutput("break_flags", 32'(flagVec()), 32'b0101);
    clearErrors();

    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [7:0] ch;
      ch = 8'(i * 13 + 7);
      if (i < DEPTH) expQ.push_back(ch);
      applyStimulus(ch, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    checkOutput("overrun_full", 32'(full), 32'd1);
    checkOutput("overrun_count", 32'(count), 32'(DEPTH));
    checkOutput("overrun_flags", 32'(flagVec()), 32'b0010);
    checkOutput("overrun_head", 32'(dout), 32'h07);
    for (int i = 0; i < DEPTH; i++) popCheck($sformatf("drain%0d", i));
    @(negedge clk);
    checkOutput("drain_empty", 32'(empty), 32'd1);
    clearErrors();

    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    waitTicks(5);
    @(negedge clk);
    checkOutput("midframe_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midframe_reset_busy", 32'(busy), 32'd0);
    checkOutput("midframe_reset_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    waitTicks(20);
    expQ.push_back(8'h55);
    applyStimulus(8'h55, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("after_reset_count", 32'(count), 32'd1);
    checkOutput("after_reset_flags", 32'(flagVec()), 32'd0);
    popCheck("after_reset_dout");
    @(negedge clk);
    checkOutput("after_reset_empty", 32'(empty), 32'd1);
    checkOutput("scoreboard_left", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
